uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the CPU data bus, downstream of the CPU memory port, in parallel with the main memory.
- CPU stores to TXDATA push bytes into a small FIFO; a baud-timed FSM serialises them 8N1, LSB first, on `tx`.
- STATUS and DIVISOR are readable with the same one-cycle read latency as the main memory, so the top-level read mux selects `rdata` using the registered `sel`.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_mmio_if.sv | 12 +
 rtl/tx_fifo.sv | 42 ++++
 rtl/uart_tx_mmio.sv | 118 +++++++++++
 tb/tb_uart_tx_mmio.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared register offsets, STATUS bit positions, FSM states and baud helper for uart_tx_mmio.
package uart_pkg;
    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;
    localparam logic [3:0] DIV_OFF    = 4'h8;
    localparam logic [3:0] CTRL_OFF   = 4'hC;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 4;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    // A divisor of 0 behaves like 1 so a bit always lasts at least one cycle.
    function automatic logic [15:0] bit_len(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction
endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU data-bus slice seen by the UART.
//   addr, wr, wdata : CPU -> UART (master drives)
//   rdata, sel      : UART -> CPU read mux (slave drives, registered)
interface uart_tx_mmio_if;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    modport master (output addr, wr, wdata, input rdata, sel);
    modport slave (input addr, wr, wdata, output rdata, sel);
endinterface

// File: rtl/tx_fifo.sv
// tx_fifo: circular FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
//   clk, reset (sync, active-low) ; push/din in ; pop in ; dout = head entry ; full, empty, count out
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0] count_t;
    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == count_t'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop) rd_ptr <= rd_ptr + ptr_t'(1);
            count <= count + count_t'(do_push) - count_t'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO, programmable divisor and STATUS register.
//   clk, reset (sync, active-low) ; bus : uart_tx_mmio_if.slave (addr/wr/wdata in, registered rdata/sel out)
//   tx : serial line, idle high ; irq : only when UART_TX_IRQ_EN is defined (idle-and-empty interrupt)
module uart_tx_mmio import uart_pkg::*; #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_mmio_if.slave bus,
    output logic          tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic          irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic hit, push, pop, full, empty, ovf, tx_n, bit_end;
    logic [3:0] off;
    logic [AW:0] count;
    logic [7:0] head, shift;
    logic [15:0] div, cnt, reload;
    logic [2:0] idx;
    logic [31:0] status, rd_mux, ctrl_rd;
    logic unused;
    state_t state, state_n;
    assign unused  = ^bus.wdata[31:16];
    assign hit     = bus.addr[31:4] == BASE_ADDR[31:4];
    assign off     = bus.addr[3:0];
    assign push    = hit && bus.wr && off == TXDATA_OFF;
    assign reload  = bit_len(div) - 16'd1;
    assign bit_end = cnt == 16'd0;
    tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.wdata[7:0]),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk) begin
        state <= !reset ? IDLE : state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = empty ? IDLE : START;
            START:   state_n = bit_end ? DATA : START;
            DATA:    state_n = (bit_end && idx == 3'd7) ? STOP : DATA;
            STOP:    state_n = !bit_end ? STOP : empty ? IDLE : START;
            default: state_n = IDLE;
        endcase
    end
    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        pop  = !empty && (state == IDLE || (state == STOP && bit_end));
        tx_n = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    end
    always_comb begin
        status               = '0;
        status[ST_FULL]      = full;
        status[ST_EMPTY]     = empty;
        status[ST_BUSY]      = state != IDLE;
        status[ST_OVF]       = ovf;
        status[ST_CNT +: 5]  = 5'(count);
        rd_mux = off == STATUS_OFF ? status :
                 off == DIV_OFF    ? {16'd0, div} :
                 off == CTRL_OFF   ? ctrl_rd : '0;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            div       <= DIV_RESET;
            cnt       <= '0;
            shift     <= '0;
            idx       <= '0;
            ovf       <= 1'b0;
            tx        <= 1'b1;
            bus.rdata <= '0;
            bus.sel   <= 1'b0;
        end else begin
            tx        <= tx_n;
            bus.sel   <= hit;
            bus.rdata <= hit ? rd_mux : '0;
            if (hit && bus.wr && off == DIV_OFF) div <= bus.wdata[15:0];
            // Reading STATUS returns the current overflow and clears it in the same edge.
            ovf <= (push && full && !pop) ? 1'b1 : (hit && off == STATUS_OFF) ? 1'b0 : ovf;
            if (pop) begin
                shift <= head;
                cnt   <= reload;
            end else if (state != IDLE) begin
                cnt <= bit_end ? reload : cnt - 16'd1;
                if (state == DATA && bit_end) begin
                    shift <= shift >> 1;
                    idx   <= idx + 3'd1;
                end
            end
        end
    end
`ifdef UART_TX_IRQ_EN
    logic irq_en;
    assign ctrl_rd = {31'd0, irq_en};
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (hit && bus.wr && off == CTRL_OFF) irq_en <= bus.wdata[0];
            irq <= irq_en && empty && state == IDLE;
        end
    end
`else
    assign ctrl_rd = '0;
`endif
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench; bus reads and serial frames are checked by separate monitors.
module tb_uart_tx_mmio;
    import uart_pkg::*;
    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] IDLE_A = 32'h0000_1000;
    typedef struct {
        logic [7:0] data;
        bit         gapless;
    } frame_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx;
`ifdef UART_TX_IRQ_EN
    logic irq;
`endif
    uart_tx_mmio_if bus();
    uart_tx_mmio dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
`ifdef UART_TX_IRQ_EN
        ,
        .irq   (irq)
`endif
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bc = 1;
    bit in_frame = 0;
    logic [31:0] rdq[$];
    frame_t txq[$];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic access(input logic [3:0] off, input logic w, input logic [31:0] d, input logic [31:0] exp);
        @(negedge clk);
        bus.addr  = {BASE[31:4], off};
        bus.wr    = w;
        bus.wdata = d;
        rdq.push_back(exp);
        @(posedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit gapless);
        access(TXDATA_OFF, 1'b1, {24'd0, b}, 32'd0);
        txq.push_back('{b, gapless});
    endtask

    task automatic idle();
        @(negedge clk);
        bus.addr  = IDLE_A;
        bus.wr    = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while ((txq.size() != 0 || in_frame) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL tx drain: %0d frames still pending after %0d cycles", txq.size(), n);
        end
    endtask

    // Read monitor: every registered hit is matched against the next expected rdata.
    initial forever begin
        @(negedge clk);
        if (bus.sel === 1'b1) begin
            if (rdq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata: unexpected sel with rdata %h at cycle %0d", bus.rdata, cyc);
            end else begin
                check("rdata", bus.rdata, rdq.pop_front());
            end
        end
    end

    // Serial monitor: samples every cycle of a frame against the expected start/data/stop levels.
    initial begin
        int e = -100;
        int s, bad, d;
        logic [7:0] got;
        logic lvl;
        frame_t f;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                s = cyc;
                d = bc;
                in_frame = 1;
                bad = 0;
                got = '0;
                if (txq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame: unexpected start bit at cycle %0d", s);
                    f = '{8'h00, 1'b0};
                end else begin
                    f = txq.pop_front();
                end
                for (int b = 0; b < 10; b++) begin
                    for (int j = 0; j < d; j++) begin
                        if (b != 0 || j != 0) @(negedge clk);
                        lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : f.data[b-1];
                        if (tx !== lvl) bad++;
                        if (b >= 1 && b <= 8 && j == 0) got[b-1] = tx;
                    end
                end
                check("frame byte", {24'd0, got}, {24'd0, f.data});
                check("frame bad samples", bad, 0);
                if (f.gapless) check("frame gap", s, e + 1);
                e = cyc;
                in_frame = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        bus.addr  = IDLE_A;
        bus.wr    = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset sel", bus.sel, 0);
        check("reset rdata", bus.rdata, 0);
        reset = 1'b1;
        access(STATUS_OFF, 1'b0, 0, 32'h2);
        idle();
        @(negedge clk);
        check("sel outside window", bus.sel, 0);
        check("idle tx", tx, 1);
        // DIVISOR=2, one byte, start-bit latency
        bc = 2;
        access(DIV_OFF, 1'b1, 32'd2, 32'd868);
        send(8'h55, 1'b0);
        idle();
        @(negedge clk);
        check("latency T+1 tx", tx, 1);
        @(negedge clk);
        check("latency T+2 tx", tx, 0);
        wait_done(100);
        // back-to-back writes overflow a 4-deep FIFO by one
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b1);
        send(8'hC3, 1'b1);
        send(8'hD4, 1'b1);
        send(8'hE5, 1'b1);
        access(TXDATA_OFF, 1'b1, 32'hF6, 32'd0);
        access(STATUS_OFF, 1'b0, 0, 32'h4D);
        access(STATUS_OFF, 1'b0, 0, 32'h45);
        idle();
        wait_done(300);
        // DIVISOR=0 behaves as one cycle per bit
        bc = 1;
        access(DIV_OFF, 1'b1, 32'd0, 32'd2);
        send(8'h01, 1'b0);
        idle();
        wait_done(100);
        // reset in the middle of data bit 3
        bc = 3;
        access(DIV_OFF, 1'b1, 32'd3, 32'd0);
        send(8'hFF, 1'b0);
        idle();
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("tx after reset", tx, 1);
        access(STATUS_OFF, 1'b0, 0, 32'h2);
        access(DIV_OFF, 1'b0, 0, 32'd868);
        idle();
        wait_done(100);
        repeat (40) @(negedge clk);
        check("no resumed frame tx", tx, 1);
`ifdef UART_TX_IRQ_EN
        bc = 2;
        access(DIV_OFF, 1'b1, 32'd2, 32'd868);
        access(CTRL_OFF, 1'b1, 32'd1, 32'd0);
        idle();
        @(negedge clk);
        check("irq at idle", irq, 1);
        access(CTRL_OFF, 1'b0, 0, 32'd1);
        send(8'h3C, 1'b0);
        idle();
        @(negedge clk);
        check("irq drops after write", irq, 0);
        wait_done(100);
        @(negedge clk);
        @(negedge clk);
        check("irq after stop bit", irq, 1);
`endif
        idle();
        repeat (5) @(negedge clk);
        check("read queue drained", rdq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
